// File: rtl/uart_frame_writer_pkg.sv
// Shared defaults and state encoding for the UART frame writer.
package uart_frame_writer_pkg;

    localparam int DEFAULT_UART_FRAME_WRITER_UART_BUS_SIZE = 8;
    localparam int DEFAULT_UART_FRAME_WRITER_IN_BUS_SIZE   = 56;

    typedef enum logic [1:0] {
        UART_FRAME_WRITER_STATE_IDLE    = 2'b00,
        UART_FRAME_WRITER_STATE_SEND    = 2'b01,
        UART_FRAME_WRITER_STATE_WAIT_TX = 2'b10,
        UART_FRAME_WRITER_STATE_DONE    = 2'b11
    } frame_writer_state_t;

    // Byte counter width; a single-byte frame still needs one bit.
    function automatic int frame_cnt_width(input int n_bytes);
        return (n_bytes <= 1) ? 1 : $clog2(n_bytes);
    endfunction

endpackage

// File: rtl/uart_frame_writer.sv
// Serializes one wide debugger frame into UART-width bytes, MSB first, and
// pulses o_wr_end once the transmitter has confirmed the last byte.
module uart_frame_writer
    import uart_frame_writer_pkg::*;
#(
    parameter int UART_BUS_SIZE    = DEFAULT_UART_FRAME_WRITER_UART_BUS_SIZE,
    parameter int DATA_IN_BUS_SIZE = DEFAULT_UART_FRAME_WRITER_IN_BUS_SIZE
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start_wr,
    input  logic [DATA_IN_BUS_SIZE-1:0] i_data_wr,
    input  logic                        i_tx_done,
    output logic                        o_tx_start,
    output logic [UART_BUS_SIZE-1:0]    o_tx_data,
    output logic                        o_wr_end,
    output logic                        o_busy
);

    localparam int N     = DATA_IN_BUS_SIZE / UART_BUS_SIZE;
    localparam int CNT_W = frame_cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    generate
        if ((DATA_IN_BUS_SIZE % UART_BUS_SIZE) != 0 || N < 1) begin : g_bad_width
            $error("DATA_IN_BUS_SIZE must be a non-zero multiple of UART_BUS_SIZE");
        end
    endgenerate

    frame_writer_state_t             state_reg, state_next;
    logic [DATA_IN_BUS_SIZE-1:0]     shift_reg, shift_next;
    logic [CNT_W-1:0]                cnt_reg, cnt_next;
    logic                            tx_start_reg, tx_start_next;
    logic [UART_BUS_SIZE-1:0]        tx_data_reg, tx_data_next;
    logic                            wr_end_reg, wr_end_next;
    logic                            busy_reg, busy_next;
    logic [DATA_IN_BUS_SIZE-1:0]     shift_advanced;

    assign shift_advanced = shift_reg << UART_BUS_SIZE;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= UART_FRAME_WRITER_STATE_IDLE;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            wr_end_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            cnt_reg      <= cnt_next;
            tx_start_reg <= tx_start_next;
            tx_data_reg  <= tx_data_next;
            wr_end_reg   <= wr_end_next;
            busy_reg     <= busy_next;
        end
    end

    // Outputs are computed on the transition into each state so the byte
    // request appears in the cycle the FSM enters SEND.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        cnt_next      = cnt_reg;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_reg;
        wr_end_next   = 1'b0;
        busy_next     = busy_reg;

        case (state_reg)
            UART_FRAME_WRITER_STATE_IDLE: begin
                if (i_start_wr) begin
                    state_next    = UART_FRAME_WRITER_STATE_SEND;
                    shift_next    = i_data_wr;
                    cnt_next      = LAST_IDX;
                    busy_next     = 1'b1;
                    tx_start_next = 1'b1;
                    tx_data_next  = i_data_wr[DATA_IN_BUS_SIZE-1 -: UART_BUS_SIZE];
                end
            end
            UART_FRAME_WRITER_STATE_SEND: begin
                state_next = UART_FRAME_WRITER_STATE_WAIT_TX;
            end
            UART_FRAME_WRITER_STATE_WAIT_TX: begin
                if (i_tx_done) begin
                    if (cnt_reg == '0) begin
                        state_next  = UART_FRAME_WRITER_STATE_DONE;
                        wr_end_next = 1'b1;
                    end else begin
                        state_next    = UART_FRAME_WRITER_STATE_SEND;
                        shift_next    = shift_advanced;
                        cnt_next      = cnt_reg - CNT_W'(1);
                        tx_start_next = 1'b1;
                        tx_data_next  = shift_advanced[DATA_IN_BUS_SIZE-1 -: UART_BUS_SIZE];
                    end
                end
            end
            UART_FRAME_WRITER_STATE_DONE: begin
                state_next = UART_FRAME_WRITER_STATE_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = UART_FRAME_WRITER_STATE_IDLE;
            end
        endcase
    end

    assign o_tx_start = tx_start_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_wr_end   = wr_end_reg;
    assign o_busy     = busy_reg;

endmodule

// File: tb/tb_uart_frame_writer.sv
// Randomized bench for uart_frame_writer with a transmitter model and a
// byte-order / timing reference derived from frame arithmetic.
module tb_uart_frame_writer;

    localparam int UB = 8;
    localparam int DB = 56;
    localparam int N  = DB / UB;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_start_wr;
    logic [DB-1:0] i_data_wr;
    logic          i_tx_done;
    logic          o_tx_start;
    logic [UB-1:0] o_tx_data;
    logic          o_wr_end;
    logic          o_busy;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int total_bytes = 0;
    int total_ends = 0;

    uart_frame_writer #(
        .UART_BUS_SIZE    (UB),
        .DATA_IN_BUS_SIZE (DB)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start_wr (i_start_wr),
        .i_data_wr  (i_data_wr),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_wr_end   (o_wr_end),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Byte i of a frame on the wire, most significant byte first.
    function automatic logic [7:0] exp_byte(input logic [DB-1:0] f, input int i);
        return 8'(f >> (UB * (N - 1 - i)));
    endfunction

    function automatic logic [DB-1:0] rand_frame();
        return DB'({$urandom(), $urandom()});
    endfunction

    // Entered and left at a negedge so frames can be issued back-to-back.
    task automatic run_frame(input logic [DB-1:0] frame, input int t_tx,
                             input bit poke_busy, input int reset_at);
        int idx = 0;
        int cd = 0;
        int post = 0;
        int acc;
        bit aborted = 1'b0;
        bit done_seen = 1'b0;
        bit finished = 1'b0;
        logic [7:0] held = 8'h00;

        i_start_wr = 1'b1;
        i_data_wr  = frame;
        @(negedge i_clk);
        i_data_wr = rand_frame();
        acc = edge_cnt;
        check_val("busy_after_accept", 64'(o_busy), 64'(1));
        for (int c = 0; c < 600 && !finished; c++) begin
            i_tx_done  = 1'b0;
            i_start_wr = 1'b0;
            i_reset    = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) i_tx_done = 1'b1;
            end
            if (aborted) begin
                if (post == 12) begin
                    check_val("rst_busy", 64'(o_busy), 64'(0));
                    check_val("rst_data", 64'(o_tx_data), 64'(0));
                end
                check_val("rst_no_start", 64'(o_tx_start), 64'(0));
                check_val("rst_no_end", 64'(o_wr_end), 64'(0));
                post--;
                if (post == 0) finished = 1'b1;
            end else if (done_seen) begin
                check_val("busy_clear", 64'(o_busy), 64'(0));
                check_val("end_once", 64'(o_wr_end), 64'(0));
                finished = 1'b1;
            end else if (o_tx_start) begin
                check_val("byte_value", 64'(o_tx_data), 64'(exp_byte(frame, idx)));
                check_val("byte_edge", 64'(edge_cnt - acc), 64'(idx * (1 + t_tx)));
                $display("byte %0d data=%02h edge=%0d", idx, o_tx_data, edge_cnt - acc);
                held = o_tx_data;
                cd = t_tx;
                idx++;
                total_bytes++;
                if ($urandom_range(1, 0) == 1) i_tx_done = 1'b1;
                if (poke_busy && idx == 3) begin
                    i_start_wr = 1'b1;
                    i_data_wr  = {7{8'h11}};
                end
                if (reset_at == idx) begin
                    i_reset = 1'b1;
                    aborted = 1'b1;
                    post = 12;
                end
            end else if (o_wr_end) begin
                done_seen = 1'b1;
                total_ends++;
                check_val("frame_len", 64'(edge_cnt - acc + 2), 64'(2 + N * (1 + t_tx)));
                check_val("byte_count", 64'(idx), 64'(N));
                check_val("busy_in_done", 64'(o_busy), 64'(1));
                $display("frame end len=%0d t_tx=%0d", edge_cnt - acc + 2, t_tx);
                if ($urandom_range(1, 0) == 1) i_tx_done = 1'b1;
            end else if (idx > 0) begin
                check_val("data_hold", 64'(o_tx_data), 64'(held));
                check_val("busy_mid", 64'(o_busy), 64'(1));
            end
            if (!finished) @(negedge i_clk);
        end
        if (!finished) check_val("frame_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        for (int c = 0; c < n; c++) begin
            i_tx_done = stray ? 1'($urandom_range(1, 0)) : 1'b0;
            check_val("idle_no_start", 64'(o_tx_start), 64'(0));
            check_val("idle_busy", 64'(o_busy), 64'(0));
            @(negedge i_clk);
        end
        i_tx_done = 1'b0;
    endtask

    initial begin
        int bytes0;
        int ends0;
        i_reset    = 1'b1;
        i_start_wr = 1'b0;
        i_tx_done  = 1'b0;
        i_data_wr  = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check_val("reset_tx_start", 64'(o_tx_start), 64'(0));
        check_val("reset_tx_data", 64'(o_tx_data), 64'(0));
        check_val("reset_wr_end", 64'(o_wr_end), 64'(0));
        check_val("reset_busy", 64'(o_busy), 64'(0));
        idle_cycles(6, 1'b1);

        run_frame(56'hA5_07_03_DEADBEEF, 4, 1'b0, -1);
        run_frame(rand_frame(), 1, 1'b0, -1);
        run_frame(rand_frame(), 3, 1'b1, -1);
        run_frame(rand_frame(), 2, 1'b0, -1);
        idle_cycles(5, 1'b1);
        run_frame(rand_frame(), 3, 1'b0, 2);
        run_frame(rand_frame(), 2, 1'b0, -1);
        idle_cycles(3, 1'b0);

        bytes0 = total_bytes;
        ends0  = total_ends;
        for (int r = 0; r < 32; r++) begin
            run_frame(rand_frame(), int'($urandom_range(6, 1)), 1'b0, -1);
        end
        check_val("burst_bytes", 64'(total_bytes - bytes0), 64'(32 * N));
        check_val("burst_ends", 64'(total_ends - ends0), 64'(32));
        idle_cycles(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
